// File: rtl/yf_loader_pkg.sv
// Shared definitions for the instruction-memory loader: frame constants
// and the loader state enumeration.
package yf_loader_pkg;

  // Byte that opens every frame
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Frame field widths
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 16;

  // Loader states, one per frame field plus the two terminal results
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_H  = 3'd1,
    CNT_L  = 3'd2,
    DATA_H = 3'd3,
    DATA_L = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } loader_state_t;

endpackage

// File: rtl/yf_imem_loader.sv
// Instruction-memory loader. Parses a framed byte stream
// (SYNC, N high, N low, N words high byte first, XOR checksum), writes the
// words to IMEM from address 0 upward and holds the CPU in reset until a
// frame with a matching checksum has been received.
module yf_imem_loader
  import yf_loader_pkg::*;
#(
  parameter int         IM_SIZE = 16,
  parameter int         IW      = 16,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [IM_SIZE-1:0] imem_addr,
  output logic [IW-1:0]      imem_wdata,
  output logic               cpu_rst,
  output logic               load_done,
  output logic               load_err,
  output logic [IM_SIZE-1:0] words_loaded
);

  loader_state_t     state;
  logic [CNT_W-1:0]  frame_len;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  word_cnt_next;
  logic [BYTE_W-1:0] chk_acc;
  logic              rx_fire;

  // The loader never back-pressures; a byte moves whenever it is offered
  assign rx_ready = 1'b1;
  assign rx_fire  = rx_valid & rx_ready;

  // Count of words completed once the current low byte is taken
  always_comb begin
    word_cnt_next = word_cnt + 1'b1;
  end

  // Frame parser, IMEM write pulse, address/word counters and checksum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst      <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      frame_len    <= '0;
      word_cnt     <= '0;
      chk_acc      <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) begin
        imem_addr <= imem_addr + 1'b1;
      end
      if (rx_fire) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (rx_data == SYNC) begin
              state        <= CNT_H;
              cpu_rst      <= 1'b1;
              load_done    <= 1'b0;
              load_err     <= 1'b0;
              words_loaded <= '0;
              chk_acc      <= '0;
              word_cnt     <= '0;
              imem_addr    <= '0;
            end
          end
          CNT_H: begin
            frame_len[15:8] <= rx_data;
            state           <= CNT_L;
          end
          CNT_L: begin
            frame_len[7:0] <= rx_data;
            if ({frame_len[15:8], rx_data} != '0) begin
              state <= DATA_H;
            end else begin
              state <= CHK;
            end
          end
          DATA_H: begin
            imem_wdata[IW-1 -: 8] <= rx_data;
            chk_acc               <= chk_acc ^ rx_data;
            state                 <= DATA_L;
          end
          DATA_L: begin
            imem_wdata[7:0] <= rx_data;
            chk_acc         <= chk_acc ^ rx_data;
            imem_we         <= 1'b1;
            words_loaded    <= words_loaded + 1'b1;
            word_cnt        <= word_cnt_next;
            if (word_cnt_next == frame_len) begin
              state <= CHK;
            end else begin
              state <= DATA_H;
            end
          end
          CHK: begin
            if (rx_data == chk_acc) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_rst   <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
              cpu_rst  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
